// File: rtl/byte_bus_reader.sv
// rtl/byte_bus_reader.sv - bus byte capture FIFO with show-ahead valid/ready output
// Optional: BYTE_BUS_READER_DROP_ZERO_EN makes a zero byte on the bus count as no load.
module byte_bus_reader #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [7:0]    bus_in,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          overflow,
    input  logic          clr_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          load_eff;
    logic          push;
    logic          pop;
    logic          drop;

`ifdef BYTE_BUS_READER_DROP_ZERO_EN
    assign load_eff = load && (bus_in != 8'h00);
`else
    assign load_eff = load;
`endif

    assign out_valid = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A full queue still accepts a byte when the head leaves in the same cycle.
    assign push      = load_eff && (!full || pop);
    assign drop      = load_eff && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
    assign count     = count_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= bus_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/byte_bus_reader.md
Name: byte_bus_reader

Overview:
- Receiving end of the shared 8-bit bus driven by the byte switch drivers.
- Samples the bus on a load strobe and queues the captured bytes in a small FIFO.
- Delivers queued bytes to a downstream consumer over a valid/ready handshake.
- Flags bytes lost to a full queue with a sticky overflow bit.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, minimum 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count output.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  bus strobe; when high, bus_in is captured at this edge.
- bus_in  input  8  shared byte bus.
- out_valid  output  1  head-of-queue byte is available.
- out_data  output  8  head-of-queue byte; 8'h00 whenever out_valid=0.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  CW  number of bytes currently queued, 0..DEPTH.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a load was dropped because the queue was full.
- clr_overflow  input  1  clears overflow.

Behaviour:
- Reset (rst=1 at clk edge):
  - count=0, read/write pointers=0, overflow=0.
  - out_valid=0, out_data=8'h00, full=0.
  - rst overrides all other inputs that cycle.
  - Reset mid-stream discards all queued bytes; there is no partial drain.
- Storage:
  - Circular buffer of DEPTH x 8 bits.
  - Write and read pointers wrap modulo DEPTH.
  - Memory contents are not reset; only pointers and count are.
- Push: occurs when load=1 and (full=0 or pop occurs the same cycle). bus_in is written at the write pointer, then the write pointer increments.
- Pop: occurs when out_valid=1 and out_ready=1. The read pointer increments.
- Show-ahead output:
  - out_data is combinationally the entry at the read pointer while out_valid=1.
  - out_valid = (count!=0).
- Latency: a byte pushed at edge N is visible on out_data/out_valid after edge N. There is no same-cycle bypass from bus_in to out_data.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Boundary conditions:
  - Empty + load: byte is queued; out_valid rises after the edge.
  - Empty + out_ready: no pop, no pointer movement.
  - Full + load + pop: both occur; count stays DEPTH; no overflow.
  - Full + load, no pop: byte dropped, queue unchanged, overflow set to 1.
  - Overflow set condition and clr_overflow in the same cycle: set wins and overflow stays 1.
  - clr_overflow alone: overflow becomes 0 at the next edge.
  - Pointer wrap from DEPTH-1 to 0 must preserve FIFO order.
- out_ready is ignored while out_valid=0.
- load and bus_in are assumed synchronous to clk.

Optional Feature:
- Macro: BYTE_BUS_READER_DROP_ZERO_EN.
- Defined:
  - A load with bus_in==8'h00 is treated as no load. Rationale: an idle byte switch drives zero.
  - No push occurs and overflow cannot be set by it.
  - Zero bytes never enter the queue.
- Undefined: 8'h00 is queued like any other value.

Test Plan:
- Reset, then load=1 for three cycles with bus_in=8'h11, 8'h22, 8'h33 and out_ready=0 -> count=3, out_valid=1, out_data=8'h11, full=0, overflow=0.
- DEPTH=4. Load 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5 with out_ready=0 -> after the 4th edge full=1; the 5th load is dropped and overflow=1, count=4. Then out_ready=1 for 4 cycles -> out_data reads A1, A2, A3, A4; count=0; out_valid=0; out_data=8'h00.
- Full queue with load=1, bus_in=8'hB0 and out_ready=1 in the same cycle -> head popped, B0 enqueued at tail, count stays 4, overflow stays 0.
- Continuous load with incrementing values 8'h01..8'h0C and out_ready=1 every cycle -> values drain in order 8'h01..8'h0C across 3 pointer wraps, count never exceeds 1, no overflow.
- overflow=1, then clr_overflow=1 together with a full-queue load -> overflow stays 1. Then clr_overflow=1 alone -> overflow=0. Then assert rst with 2 bytes queued -> count=0, out_valid=0 next cycle.
- With BYTE_BUS_READER_DROP_ZERO_EN defined, load bus_in=8'h00, 8'h5A, 8'h00 -> count=1, out_data=8'h5A. Without the macro -> count=3, out_data=8'h00 with out_valid=1.
